// File: rtl/jk_cmd_t_reg_pkg.sv
// Shared definitions for the JK-command register: command encoding,
// controller states and the per-bit JK-to-T conversion.
package jk_cmd_t_reg_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } ctrl_state_t;

    // Toggle bit a T flip-flop needs so that its next state follows JK rules.
    function automatic logic jk_toggle_bit(input logic j, input logic k, input logic q);
        logic t;
        case ({j, k})
            JK_HOLD: t = 1'b0;
            JK_CLR:  t = q;
            JK_SET:  t = ~q;
            default: t = 1'b1;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/jk_cmd_t_reg_t_ff_bank.sv
// Bank of WIDTH T flip-flops with a common enable and synchronous
// active-low reset.
module t_ff_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state always uses non-blocking assignment so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/jk_cmd_t_reg.sv
// JK-behaviour register built on T flip-flops, fed by a small command FIFO
// with a saturating count of toggled bits.
module jk_cmd_t_reg
    import jk_cmd_t_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [WIDTH-1:0]       cmd_j,
    input  logic [WIDTH-1:0]       cmd_k,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       t_last,
    output logic                   apply_pulse,
    output logic [CNT_W-1:0]       toggle_cnt,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int PCW = $clog2(WIDTH + 1);
    localparam int SW  = ((CNT_W > PCW) ? CNT_W : PCW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] mem_j [DEPTH];
    logic [WIDTH-1:0] mem_k [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head_j;
    logic [WIDTH-1:0] head_k;
    logic [WIDTH-1:0] t_vec;
    logic [SW-1:0]    pop_cnt;
    logic [SW-1:0]    cnt_sum;
    logic [CNT_W-1:0] cnt_nxt;
    ctrl_state_t      state;
    ctrl_state_t      state_nxt;

    // Ready depends only on registered occupancy: no pass-through when full.
    assign cmd_ready = (fifo_level != LW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = en && (fifo_level != '0);

    // NOTE: the storage array is deliberately not reset; occupancy and
    // pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_j[wr_ptr] <= cmd_j;
            mem_k[wr_ptr] <= cmd_k;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    assign head_j = mem_j[rd_ptr];
    assign head_k = mem_k[rd_ptr];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        t_vec   = '0;
        pop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t_vec[i] = jk_toggle_bit(head_j[i], head_k[i], q[i]);
            pop_cnt  = pop_cnt + SW'(t_vec[i]);
        end
        cnt_sum = SW'(toggle_cnt) + pop_cnt;
        cnt_nxt = (cnt_sum > SW'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end

    t_ff_bank #(
        .WIDTH (WIDTH)
    ) u_t_ff_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pop),
        .t     (t_vec),
        .q     (q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_last      <= '0;
            apply_pulse <= 1'b0;
            toggle_cnt  <= '0;
        end else begin
            apply_pulse <= pop;
            if (pop) begin
                t_last     <= t_vec;
                toggle_cnt <= cnt_nxt;
            end
        end
    end

    // Controller state is informational; it tracks FIFO emptiness only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (push) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (pop && !push && fifo_level == LW'(1)) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_jk_cmd_t_reg.sv
// Scoreboard bench for jk_cmd_t_reg: a reference FIFO/JK model queues the
// expected result of every applied command, checked when apply_pulse fires.
module tb_jk_cmd_t_reg;
    import jk_cmd_t_reg_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic [WIDTH-1:0] j;
        logic [WIDTH-1:0] k;
    } cmd_s;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] t;
        int               cnt;
    } exp_s;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_j;
    logic [WIDTH-1:0] cmd_k;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t_last;
    logic             apply_pulse;
    logic [CNT_W-1:0] toggle_cnt;
    logic [LW-1:0]    fifo_level;

    int n_vec  = 0;
    int n_miss = 0;

    cmd_s             cmd_fifo[$];
    exp_s             sb[$];
    logic [WIDTH-1:0] m_q     = '0;
    logic [WIDTH-1:0] m_t     = '0;
    int               m_cnt   = 0;
    logic             m_pulse = 1'b0;
    logic             m_push  = 1'b0;

    jk_cmd_t_reg #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_j       (cmd_j),
        .cmd_k       (cmd_k),
        .q           (q),
        .t_last      (t_last),
        .apply_pulse (apply_pulse),
        .toggle_cnt  (toggle_cnt),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: registered-occupancy ready, pop before push each edge.
    always @(posedge clk) begin
        cmd_s             c;
        exp_s             e;
        logic [WIDTH-1:0] t;
        logic             do_pop;
        if (!rst_n) begin
            cmd_fifo.delete();
            sb.delete();
            m_q     = '0;
            m_t     = '0;
            m_cnt   = 0;
            m_pulse = 1'b0;
            m_push  = 1'b0;
        end else begin
            do_pop  = en && (cmd_fifo.size() != 0);
            m_push  = cmd_valid && (cmd_fifo.size() != DEPTH);
            m_pulse = do_pop;
            if (do_pop) begin
                c     = cmd_fifo.pop_front();
                t     = (c.j & ~m_q) | (c.k & m_q);
                m_q   = m_q ^ t;
                m_t   = t;
                m_cnt = m_cnt + $countones(t);
                if (m_cnt > CMAX) m_cnt = CMAX;
                e.q   = m_q;
                e.t   = t;
                e.cnt = m_cnt;
                sb.push_back(e);
            end
            if (m_push) begin
                c.j = cmd_j;
                c.k = cmd_k;
                cmd_fifo.push_back(c);
            end
        end
    end

    always @(negedge clk) begin
        exp_s e;
        check("apply_pulse", 32'(apply_pulse), 32'(m_pulse));
        check("q", 32'(q), 32'(m_q));
        check("t_last", 32'(t_last), 32'(m_t));
        check("toggle_cnt", 32'(toggle_cnt), m_cnt);
        check("fifo_level", 32'(fifo_level), cmd_fifo.size());
        check("cmd_ready", 32'(cmd_ready), 32'(cmd_fifo.size() != DEPTH));
        if (apply_pulse) begin
            check("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_q", 32'(q), 32'(e.q));
                check("sb_t", 32'(t_last), 32'(e.t));
                check("sb_cnt", 32'(toggle_cnt), e.cnt);
            end
        end
    end

    // Present a command from a falling edge, hold until accepted, return on
    // the falling edge after the accepting edge with cmd_valid still high.
    task automatic send(input logic [WIDTH-1:0] j, input logic [WIDTH-1:0] k);
        bit ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_j     = j;
        cmd_k     = k;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(posedge clk);
            #1;
            ok = m_push;
        end
        check("accept", 32'(ok), 1);
        @(negedge clk);
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        cmd_valid = 1'b0;
        cmd_j     = '0;
        cmd_k     = '0;
        repeat (2) @(negedge clk);
        check("rst_q", 32'(q), 0);
        check("rst_t_last", 32'(t_last), 0);
        check("rst_pulse", 32'(apply_pulse), 0);
        check("rst_cnt", 32'(toggle_cnt), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_ready", 32'(cmd_ready), 1);
        rst_n = 1'b1;
        en    = 1'b1;

        // Basic set, then toggle-all and a single clear.
        send(4'b1010, 4'b0000);
        idle();
        @(negedge clk);
        check("set_q", 32'(q), 32'b1010);
        check("set_t_last", 32'(t_last), 32'b1010);
        check("set_pulse", 32'(apply_pulse), 1);
        check("set_cnt", 32'(toggle_cnt), 2);
        @(negedge clk);
        check("set_pulse_drop", 32'(apply_pulse), 0);

        send(4'b1111, 4'b1111);
        idle();
        @(negedge clk);
        check("tog_q", 32'(q), 32'b0101);
        check("tog_cnt", 32'(toggle_cnt), 6);

        send(4'b0000, 4'b0100);
        idle();
        @(negedge clk);
        check("clr_q", 32'(q), 32'b0001);
        check("clr_t_last", 32'(t_last), 32'b0100);
        check("clr_cnt", 32'(toggle_cnt), 7);

        // Backpressure: fill with en low, attempt a fifth push, then drain.
        en = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(WIDTH'($urandom), WIDTH'($urandom));
        check("bp_level", 32'(fifo_level), DEPTH);
        check("bp_ready", 32'(cmd_ready), 0);
        check("bp_q_hold", 32'(q), 32'b0001);
        @(negedge clk);
        check("bp_full_reject", 32'(fifo_level), DEPTH);
        idle();
        en = 1'b1;
        @(negedge clk);
        check("bp_ready_back", 32'(cmd_ready), 1);
        check("bp_level_3", 32'(fifo_level), DEPTH - 1);
        repeat (DEPTH) @(negedge clk);
        check("bp_drained", 32'(fifo_level), 0);

        // Simultaneous push/pop at level 2 across pointer wrap.
        en = 1'b0;
        repeat (2) send(WIDTH'($urandom), WIDTH'($urandom));
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(WIDTH'($urandom), WIDTH'($urandom));
            check("pp_level", 32'(fifo_level), 2);
        end
        idle();
        repeat (4) @(negedge clk);

        // Saturation of the toggle counter.
        do_reset();
        repeat (3) send(4'b1111, 4'b1111);
        idle();
        repeat (2) @(negedge clk);
        check("sat_cnt", 32'(toggle_cnt), CMAX);
        check("sat_q", 32'(q), 32'b1111);
        send(4'b0000, 4'b1111);
        idle();
        repeat (2) @(negedge clk);
        check("sat_hold", 32'(toggle_cnt), CMAX);
        check("sat_clr_q", 32'(q), 0);

        // Reset with a full FIFO and en high on the reset edge.
        en = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(4'b1111, 4'b0000);
        idle();
        check("rm_full", 32'(fifo_level), DEPTH);
        rst_n = 1'b0;
        en    = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        check("rm_q", 32'(q), 0);
        check("rm_level", 32'(fifo_level), 0);
        check("rm_ready", 32'(cmd_ready), 1);
        check("rm_cnt", 32'(toggle_cnt), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rm_no_apply", 32'(apply_pulse), 0);
            check("rm_q_hold", 32'(q), 0);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
